// File: rtl/dff_ctrl_pkg.sv
// rtl/dff_ctrl_pkg.sv - shared types and width helper for the capture controller
package dff_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        REPORT  = 2'd2
    } state_t;

    // width of a counter or index holding 0..n-1, never narrower than one bit
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dff_capture_ctrl_if.sv
// rtl/dff_capture_ctrl_if.sv - requester/controller bundle for the capture controller
interface dff_capture_ctrl_if #(
    parameter int N = 2
);
    logic [N-1:0] req;
    logic [N-1:0] d;
    logic [N-1:0] gnt;
    logic         q;
    logic         q_vld;
    logic         err;
    logic         busy;

    modport master (
        output req, d,
        input  gnt, q, q_vld, err, busy
    );

    modport slave (
        input  req, d,
        output gnt, q, q_vld, err, busy
    );

endinterface

// File: rtl/rr_arb.sv
// rtl/rr_arb.sv - combinational round-robin pick starting at a pointer
module rr_arb
    import dff_ctrl_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = cnt_w(N)
) (
    input  logic [N-1:0]  eligible,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] win,
    output logic          any
);

    logic [N-1:0]  rot;
    logic [PW-1:0] off;
    logic [PW:0]   sum;

    // rotate so that bit 0 of rot is requester ptr
    assign rot = N'({eligible, eligible} >> ptr);

    // lowest set bit of the rotated vector is the first eligible index at or after ptr
    always_comb begin
        any = 1'b0;
        off = '0;
        for (int j = 0; j < N; j++) begin
            if (!any && rot[j]) begin
                any = 1'b1;
                off = PW'(j);
            end
        end
    end

    // map the rotated position back to a requester index and build the one-hot grant
    always_comb begin
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (PW+1)'(N)) begin
            sum = sum - (PW+1)'(N);
        end
        win = sum[PW-1:0];
        gnt = any ? (N'(1) << win) : '0;
    end

endmodule

// File: rtl/dff_capture_ctrl.sv
// rtl/dff_capture_ctrl.sv - scheduled capture sequencer for a bank of 1-bit flop slots
module dff_capture_ctrl
    import dff_ctrl_pkg::*;
#(
    parameter int           N       = 2,
    parameter logic [N-1:0] NEGATE  = '0,
    parameter int           TIMEOUT = 16
) (
    input  logic              c,
    input  logic              rst_n,
    dff_capture_ctrl_if.slave bus
);

    localparam int            PW    = cnt_w(N);
    localparam int            TW    = cnt_w(TIMEOUT);
    localparam logic [PW-1:0] PLAST = PW'(N - 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [N-1:0]  slot_q, slot_d;
    logic [N-1:0]  fill_q, fill_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          q_q, q_d;
    logic          q_vld_q, q_vld_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;

    logic [N-1:0]  eligible;
    logic [N-1:0]  arb_gnt;
    logic [PW-1:0] arb_win;
    logic          arb_any;

    // no grants while reporting or held in reset; filled slots wait for the next round
    assign eligible = (rst_n && (state_q != REPORT)) ? (bus.req & ~fill_q) : '0;

    rr_arb #(
        .N  (N),
        .PW (PW)
    ) u_arb (
        .eligible (eligible),
        .ptr      (ptr_q),
        .gnt      (arb_gnt),
        .win      (arb_win),
        .any      (arb_any)
    );

    assign bus.gnt   = arb_gnt;
    assign bus.q     = q_q;
    assign bus.q_vld = q_vld_q;
    assign bus.err   = err_q;
    assign bus.busy  = busy_q;

    // capture, pointer advance, round sequencing and timeout
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        fill_d  = fill_q;
        ptr_d   = ptr_q;
        tcnt_d  = tcnt_q;
        q_d     = q_q;
        q_vld_d = 1'b0;
        err_d   = 1'b0;

        if (arb_any) begin
            slot_d = (slot_q & ~arb_gnt) | (bus.d & arb_gnt);
            fill_d = fill_q | arb_gnt;
            ptr_d  = (arb_win == PLAST) ? '0 : arb_win + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    tcnt_d  = '0;
                    state_d = (&fill_d) ? REPORT : COLLECT;
                end
            end
            COLLECT: begin
                tcnt_d = tcnt_q + 1'b1;
                // completion takes priority over a timeout in the same cycle
                if (&fill_d) begin
                    state_d = REPORT;
                end else if (tcnt_q == TLAST) begin
                    state_d = IDLE;
                    fill_d  = '0;
                    err_d   = 1'b1;
                end
            end
            REPORT: begin
                state_d = IDLE;
                fill_d  = '0;
            end
            default: begin
                state_d = IDLE;
                fill_d  = '0;
            end
        endcase

        // result is latched from the slot contents including the completing capture
        if ((state_q != REPORT) && (state_d == REPORT)) begin
            q_vld_d = 1'b1;
            q_d     = &(slot_d ^ NEGATE);
        end

        busy_d = (state_d != IDLE);
    end

    // state and registered outputs with synchronous active-low reset
    always_ff @(posedge c) begin
        if (!rst_n) begin
            state_q <= IDLE;
            slot_q  <= '0;
            fill_q  <= '0;
            ptr_q   <= '0;
            tcnt_q  <= '0;
            q_q     <= 1'b0;
            q_vld_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            fill_q  <= fill_d;
            ptr_q   <= ptr_d;
            tcnt_q  <= tcnt_d;
            q_q     <= q_d;
            q_vld_q <= q_vld_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: tb/tb_dff_capture_ctrl.sv
// tb/tb_dff_capture_ctrl.sv - self-checking bench for dff_capture_ctrl
module tb_dff_capture_ctrl;

    logic c = 1'b0;
    logic rst_n;

    always #5 c = ~c;

    // instance 0: N=2 no invert, 1: N=2 invert slot 0, 2: N=3 invert slot 2, short timeout
    dff_capture_ctrl_if #(.N(2)) ifa ();
    dff_capture_ctrl_if #(.N(2)) ifb ();
    dff_capture_ctrl_if #(.N(3)) ifc ();

    dff_capture_ctrl #(.N(2), .NEGATE(2'b00), .TIMEOUT(16)) dut_a (.c(c), .rst_n(rst_n), .bus(ifa));
    dff_capture_ctrl #(.N(2), .NEGATE(2'b01), .TIMEOUT(16)) dut_b (.c(c), .rst_n(rst_n), .bus(ifb));
    dff_capture_ctrl #(.N(3), .NEGATE(3'b100), .TIMEOUT(5)) dut_c (.c(c), .rst_n(rst_n), .bus(ifc));

    logic [2:0] req_v [3];
    logic [2:0] d_v   [3];

    assign ifa.req = req_v[0][1:0];
    assign ifa.d   = d_v[0][1:0];
    assign ifb.req = req_v[1][1:0];
    assign ifb.d   = d_v[1][1:0];
    assign ifc.req = req_v[2];
    assign ifc.d   = d_v[2];

    logic [2:0] o_gnt  [3];
    logic       o_q    [3];
    logic       o_qv   [3];
    logic       o_err  [3];
    logic       o_busy [3];

    assign o_gnt[0]  = {1'b0, ifa.gnt};
    assign o_gnt[1]  = {1'b0, ifb.gnt};
    assign o_gnt[2]  = ifc.gnt;
    assign o_q[0]    = ifa.q;
    assign o_q[1]    = ifb.q;
    assign o_q[2]    = ifc.q;
    assign o_qv[0]   = ifa.q_vld;
    assign o_qv[1]   = ifb.q_vld;
    assign o_qv[2]   = ifc.q_vld;
    assign o_err[0]  = ifa.err;
    assign o_err[1]  = ifb.err;
    assign o_err[2]  = ifc.err;
    assign o_busy[0] = ifa.busy;
    assign o_busy[1] = ifb.busy;
    assign o_busy[2] = ifc.busy;

    // reference model: captured-bit set, fairness pointer, collect-cycle age, report flag
    int         mN   [3] = '{2, 2, 3};
    int         mT   [3] = '{16, 16, 5};
    logic [2:0] mneg [3] = '{3'b000, 3'b001, 3'b100};
    logic [2:0] mfill[3];
    logic [2:0] mslot[3];
    int         mptr [3];
    int         mcoll[3];
    bit         mrep [3];
    bit         mqv  [3];
    bit         mq   [3];
    bit         merr [3];
    bit         mbusy[3];

    logic [2:0] lg_gnt [3][1024];
    logic       lg_q   [3][1024];
    logic       lg_qv  [3][1024];
    logic       lg_err [3][1024];
    logic       lg_busy[3][1024];

    int total;
    int bad;
    int cyc;
    int c0, c1, c2, c3, c4;
    int cnt;

    task automatic chk(input string tag, input int k, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s inst=%0d cyc=%0d observed=%h expected=%h", tag, k, cyc, obs, exp);
        end
    endtask

    task automatic model_reset(input int k);
        mfill[k] = '0;
        mslot[k] = '0;
        mptr[k]  = 0;
        mcoll[k] = -1;
        mrep[k]  = 1'b0;
        mqv[k]   = 1'b0;
        mq[k]    = 1'b0;
        merr[k]  = 1'b0;
        mbusy[k] = 1'b0;
    endtask

    task automatic step_all();
        logic [2:0] g;
        logic [2:0] mask;
        int gi;
        req_v[1] = req_v[0];
        d_v[1]   = d_v[0];
        @(negedge c);
        for (int k = 0; k < 3; k++) begin
            mask = 3'((1 << mN[k]) - 1);
            g    = '0;
            gi   = -1;
            if (rst_n && !mrep[k]) begin
                for (int off = 0; off < mN[k]; off++) begin
                    int idx;
                    idx = (mptr[k] + off) % mN[k];
                    if (gi < 0 && req_v[k][idx] && !mfill[k][idx]) begin
                        gi     = idx;
                        g[idx] = 1'b1;
                    end
                end
            end
            lg_gnt[k][cyc]  = o_gnt[k];
            lg_q[k][cyc]    = o_q[k];
            lg_qv[k][cyc]   = o_qv[k];
            lg_err[k][cyc]  = o_err[k];
            lg_busy[k][cyc] = o_busy[k];
            chk("gnt", k, {1'b0, o_gnt[k]}, {1'b0, g});
            chk("q_vld", k, {3'b0, o_qv[k]}, {3'b0, mqv[k]});
            chk("err", k, {3'b0, o_err[k]}, {3'b0, merr[k]});
            chk("busy", k, {3'b0, o_busy[k]}, {3'b0, mbusy[k]});
            if (mqv[k]) chk("q", k, {3'b0, o_q[k]}, {3'b0, mq[k]});

            if (!rst_n) begin
                model_reset(k);
            end else begin
                mqv[k]  = 1'b0;
                merr[k] = 1'b0;
                if (mrep[k]) begin
                    mrep[k]  = 1'b0;
                    mfill[k] = '0;
                end else if (gi >= 0 || mcoll[k] >= 0) begin
                    if (gi >= 0) begin
                        mslot[k][gi] = d_v[k][gi];
                        mfill[k][gi] = 1'b1;
                        mptr[k]      = (gi + 1) % mN[k];
                    end
                    if ((mfill[k] & mask) == mask) begin
                        mrep[k]  = 1'b1;
                        mqv[k]   = 1'b1;
                        mq[k]    = (((mslot[k] ^ mneg[k]) & mask) == mask);
                        mcoll[k] = -1;
                    end else if (mcoll[k] < 0) begin
                        mcoll[k] = 0;
                    end else if (mcoll[k] == mT[k] - 1) begin
                        mfill[k] = '0;
                        mcoll[k] = -1;
                        merr[k]  = 1'b1;
                    end else begin
                        mcoll[k]++;
                    end
                end
                mbusy[k] = mrep[k] || (mcoll[k] >= 0);
            end
        end
        @(posedge c);
        #1;
        cyc++;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        for (int k = 0; k < 3; k++) begin
            model_reset(k);
            d_v[k] = '0;
        end
        // reset with every requester asserting: nothing may be granted
        rst_n    = 1'b0;
        req_v[0] = 3'b011;
        req_v[2] = 3'b111;
        req_v[1] = req_v[0];
        d_v[1]   = d_v[0];
        @(posedge c);
        #1;
        step_all();
        step_all();
        chk("rst_gnt", 0, {1'b0, lg_gnt[0][1]}, 4'd0);
        chk("rst_gnt", 2, {1'b0, lg_gnt[2][1]}, 4'd0);
        chk("rst_q", 0, {3'b0, lg_q[0][1]}, 4'd0);
        chk("rst_busy", 2, {3'b0, lg_busy[2][1]}, 4'd0);
        rst_n = 1'b1;

        // continuous full requests, all-ones data
        c0 = cyc;
        d_v[0] = 3'b011;
        d_v[2] = 3'b111;
        repeat (9) step_all();
        chk("p1_gnt0", 0, {1'b0, lg_gnt[0][c0]},     4'b0001);
        chk("p1_gnt1", 0, {1'b0, lg_gnt[0][c0 + 1]}, 4'b0010);
        chk("p1_gnt2", 0, {1'b0, lg_gnt[0][c0 + 2]}, 4'b0000);
        chk("p1_qv", 0, {3'b0, lg_qv[0][c0 + 2]}, 4'd1);
        chk("p1_q", 0, {3'b0, lg_q[0][c0 + 2]}, 4'd1);
        chk("p1_q", 1, {3'b0, lg_q[1][c0 + 2]}, 4'd0);
        chk("p1_rep", 0, {1'b0, lg_gnt[0][c0 + 3]}, 4'b0001);
        chk("p1_qv2", 0, {3'b0, lg_qv[0][c0 + 5]}, 4'd1);
        chk("p1_n3_g0", 2, {1'b0, lg_gnt[2][c0]},     4'b0001);
        chk("p1_n3_g1", 2, {1'b0, lg_gnt[2][c0 + 1]}, 4'b0010);
        chk("p1_n3_g2", 2, {1'b0, lg_gnt[2][c0 + 2]}, 4'b0100);
        chk("p1_n3_qv", 2, {3'b0, lg_qv[2][c0 + 3]}, 4'd1);

        // data 10 on the N=2 pair; requester 0 drops out on the N=3 block
        c1 = cyc;
        d_v[0]   = 3'b010;
        req_v[2] = 3'b110;
        repeat (6) step_all();
        req_v[2] = 3'b111;
        repeat (3) step_all();
        chk("p2_q", 0, {3'b0, lg_q[0][c1 + 2]}, 4'd0);
        chk("p2_q", 1, {3'b0, lg_q[1][c1 + 2]}, 4'd1);
        chk("p2_qv", 1, {3'b0, lg_qv[1][c1 + 2]}, 4'd1);
        chk("p2_skip0", 2, {1'b0, lg_gnt[2][c1 + 3]}, 4'b0010);
        chk("p2_stall", 2, {1'b0, lg_gnt[2][c1 + 5]}, 4'b0000);
        chk("p2_resume0", 2, {1'b0, lg_gnt[2][c1 + 6]}, 4'b0001);
        chk("p2_n3_qv", 2, {3'b0, lg_qv[2][c1 + 7]}, 4'd1);

        // only requester 0 on the pair: one capture then timeout
        c2 = cyc;
        req_v[0] = 3'b001;
        d_v[0]   = 3'b001;
        req_v[2] = 3'b000;
        repeat (17) step_all();
        req_v[0] = 3'b000;
        repeat (3) step_all();
        cnt = 0;
        for (int i = c2; i < c2 + 17; i++) if (lg_gnt[0][i] != 3'b000) cnt++;
        chk("to_grants", 0, 4'(cnt), 4'd1);
        cnt = 0;
        for (int i = c2; i < c2 + 20; i++) if (lg_qv[0][i]) cnt++;
        chk("to_no_qv", 0, 4'(cnt), 4'd0);
        chk("to_err_early", 0, {3'b0, lg_err[0][c2 + 16]}, 4'd0);
        chk("to_err", 0, {3'b0, lg_err[0][c2 + 17]}, 4'd1);
        chk("to_busy_pre", 0, {3'b0, lg_busy[0][c2 + 16]}, 4'd1);
        chk("to_busy", 0, {3'b0, lg_busy[0][c2 + 17]}, 4'd0);
        chk("to_err_n3", 2, {3'b0, lg_err[2][c2 + 5]}, 4'd1);
        chk("to_busy_n3", 2, {3'b0, lg_busy[2][c2 + 5]}, 4'd0);

        // requester 1 arrives exactly on the last allowed collect cycle
        c3 = cyc;
        d_v[0]   = 3'b011;
        req_v[0] = 3'b001;
        step_all();
        req_v[0] = 3'b000;
        repeat (15) step_all();
        req_v[0] = 3'b010;
        step_all();
        req_v[0] = 3'b000;
        repeat (3) step_all();
        chk("race_gnt", 0, {1'b0, lg_gnt[0][c3 + 16]}, 4'b0010);
        chk("race_qv", 0, {3'b0, lg_qv[0][c3 + 17]}, 4'd1);
        chk("race_q", 0, {3'b0, lg_q[0][c3 + 17]}, 4'd1);
        cnt = 0;
        for (int i = c3; i < c3 + 20; i++) if (lg_err[0][i]) cnt++;
        chk("race_no_err", 0, 4'(cnt), 4'd0);

        // reset in the middle of a round with one slot filled
        c4 = cyc;
        req_v[0] = 3'b001;
        step_all();
        rst_n    = 1'b0;
        req_v[0] = 3'b011;
        step_all();
        rst_n    = 1'b1;
        req_v[0] = 3'b010;
        step_all();
        req_v[0] = 3'b000;
        step_all();
        req_v[0] = 3'b001;
        step_all();
        req_v[0] = 3'b000;
        repeat (2) step_all();
        chk("mid_rst_gnt", 0, {1'b0, lg_gnt[0][c4 + 1]}, 4'd0);
        chk("mid_rst_busy", 0, {3'b0, lg_busy[0][c4 + 2]}, 4'd0);
        chk("mid_rst_g1", 0, {1'b0, lg_gnt[0][c4 + 2]}, 4'b0010);
        chk("mid_rst_noqv", 0, {3'b0, lg_qv[0][c4 + 3]}, 4'd0);
        chk("mid_rst_qv", 0, {3'b0, lg_qv[0][c4 + 5]}, 4'd1);

        // random traffic with varying request density and occasional resets
        for (int i = 0; i < 400; i++) begin
            if ((i / 100) % 2 == 0) begin
                req_v[0] = 3'($urandom);
                req_v[2] = 3'($urandom);
            end else begin
                req_v[0] = 3'($urandom & $urandom & $urandom);
                req_v[2] = 3'($urandom & $urandom & $urandom);
            end
            d_v[0] = 3'($urandom);
            d_v[2] = 3'($urandom);
            rst_n  = ($urandom_range(0, 79) != 0);
            step_all();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dff_capture_ctrl.md
# dff_capture_ctrl

Sequencer and arbiter that shares the single capture path of a bank of 1-bit flop slots among N requesters. Each requester deposits one bit per round via a req/gnt handshake. When every slot has been filled, the block reports the AND-reduction of the slots, each optionally negated, and starts a new round. It sits in front of the flop-pair datapath and replaces the free-running per-bit capture with a scheduled one that reports completion and timeouts.

## Interface
- `N`, default 2: number of requesters and slots, ≥1.
- `NEGATE`, default `{N{1'b0}}`: per-slot invert mask; slot i contributes `~bit` when `NEGATE[i]=1`.
- `TIMEOUT`, default 16: COLLECT cycles allowed before a round is aborted, ≥2.

Ports:
- `c`  in  1: clock, rising edge.
- `rst_n`  in  1: reset. One clock; reset is synchronous and active-low.
- `req`  in  N: request from requester i to deposit `d[i]`.
- `d`  in  N: data bit of requester i, sampled only when granted.
- `gnt`  out  N: one-hot or zero, combinational; capture occurs at the edge where `req[i]&gnt[i]`.
- `q`  out  1: round result, registered, valid only while `q_vld`.
- `q_vld`  out  1: one-cycle pulse, round complete.
- `err`  out  1: one-cycle pulse, round aborted by timeout.
- `busy`  out  1: state ≠ IDLE.

## Operation
- State: `slot[N]`, `fill[N]` mask, round-robin pointer `ptr` (0..N-1), timeout counter `tcnt`, FSM with states IDLE, COLLECT, REPORT.
- Arbitration: eligible = `req & ~fill`. Grant the first eligible index at or after `ptr`, wrapping. `ptr` ← winner+1 mod N on each grant. At most one grant per cycle. `gnt=0` in REPORT and while `rst_n=0`.
- A granted capture sets `slot[i]←d[i]` and `fill[i]←1`. Requests to already-filled slots stall until the next round.
- IDLE: on a grant, go to COLLECT with `tcnt←0`. If that grant completes `fill` (N=1), go directly to REPORT.
- COLLECT: `tcnt` increments each cycle. If `fill|grant` is all ones, go to REPORT. Otherwise, if `tcnt==TIMEOUT-1`, go to IDLE, clear `fill`, and pulse `err`. If completion and timeout occur in the same cycle, completion wins with no `err`.
- REPORT: for exactly one cycle, `q_vld=1` and `q = &(slot ^ NEGATE)`. Then go to IDLE with `fill←0`. `slot` holds its value until overwritten.
- Reset, applied synchronously at any time including mid-round: state IDLE, `fill=0`, `slot=0`, `ptr=0`, `tcnt=0`, `q=0`, `q_vld=0`, `err=0`, `busy=0`. A request present during the reset cycle is not granted.

## Timing
- Grant is same-cycle: with `req[i]` high at cycle k and i winning, the capture happens at the edge ending cycle k.
- Last capture at the edge ending cycle k gives REPORT in cycle k+1 with `q_vld=1`, and IDLE in k+2. A new grant is possible in k+2.
- Minimum round is N+1 cycles: N grants plus 1 REPORT.
- Timeout: first capture ends cycle k, which enters COLLECT. If the round is still incomplete, `err` pulses in cycle k+TIMEOUT+1 and the block is IDLE in the same cycle.
- `q`, `q_vld`, `err` and `busy` are registered. `gnt` is combinational from `req`, `fill`, `ptr` and state.

## Structure
- Package `dff_ctrl_pkg`: `state_t` enum (IDLE, COLLECT, REPORT) and a `clog2`-based width constant helper for `ptr` and `tcnt`.
- Sub-module `rr_arb #(N)`: combinational round-robin pick from `eligible` and `ptr`, returning a one-hot grant and the winner index. The pointer register stays in `dff_capture_ctrl`.
- Slot and fill storage, FSM and timeout counter live in the top block.

## Test plan
- N=2, NEGATE=0. Apply `req=2'b11` with `d=2'b11` continuously. Expected: `gnt` 01 then 10, `q_vld` in cycle 3 with `q=1`, then the pattern repeats every 3 cycles.
- N=2, NEGATE=2'b01, `d=2'b10`, both requesting. Expected: `q=1`. Repeat with `d=2'b11`. Expected: `q=0`.
- Hold `req=2'b01` only. Expected: one grant, then `gnt=0` while stalled, `err` pulse exactly TIMEOUT+1 cycles after the capture, `busy` drops in the same cycle, no `q_vld`.
- Requester 1 arrives on exactly the cycle where `tcnt==TIMEOUT-1`. Expected: `q_vld` next cycle and no `err`.
- N=3, all requesting continuously. Expected: grant order 0,1,2 per round. Then deassert `req[0]` mid-round and confirm the fairness pointer skips 0 and resumes at 0 once it requests again.
- Assert `rst_n=0` for one cycle in COLLECT with one slot filled. Expected: all outputs 0, `gnt=0` during reset, and the next round needs all N captures again.
